// File: rtl/ula_seq.sv
// Command sequencer feeding a combinational 8-bit ULA: FIFO-buffered (a, b, op, tag) in, tagged in-order results out.
// Optional divide-by-zero guard enabled with macro ULA_SEQ_DIVZERO_CHK_EN.
module ula_seq #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [1:0]       cmd_op,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [7:0]       ula_a,
  output logic [7:0]       ula_b,
  output logic [1:0]       ula_op,
  input  logic [7:0]       ula_r,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_r,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [7:0]       a;
    logic [7:0]       b;
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t          state;
  cmd_t            mem [DEPTH];
  cmd_t            head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [TAG_W-1:0] tag_q;
  logic            dz_q;
  logic            push;
  logic            pop;
  logic            not_empty;
  logic            dz;
  logic [7:0]      b_eff;

  assign head      = mem[rd_ptr];
  assign not_empty = (count != '0);
  assign cmd_ready = (count != (AW+1)'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  // Pop whenever the stage is free: idle, or the held response is being taken.
  assign pop       = not_empty && ((state == IDLE) || ((state == RESP) && rsp_ready));

`ifdef ULA_SEQ_DIVZERO_CHK_EN
  assign dz    = (head.op == 2'b11) && (head.b == 8'd0);
  assign b_eff = dz ? 8'd1 : head.b;
`else
  assign dz    = 1'b0;
  assign b_eff = head.b;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, op: cmd_op, tag: cmd_tag};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ula_a     <= '0;
      ula_b     <= '0;
      ula_op    <= '0;
      tag_q     <= '0;
      dz_q      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_r     <= '0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            ula_a  <= head.a;
            ula_b  <= b_eff;
            ula_op <= head.op;
            tag_q  <= head.tag;
            dz_q   <= dz;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          rsp_valid <= 1'b1;
          rsp_r     <= dz_q ? 8'hFF : ula_r;
          rsp_tag   <= tag_q;
          rsp_err   <= dz_q;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (pop) begin
              ula_a  <= head.a;
              ula_b  <= b_eff;
              ula_op <= head.op;
              tag_q  <= head.tag;
              dz_q   <= dz;
              state  <= ISSUE;
            end else begin
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// Randomized and directed bench for ula_seq against a queue-based reference model.
module tb_ula_seq;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
`ifdef ULA_SEQ_DIVZERO_CHK_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [7:0]       cmd_a = '0;
  logic [7:0]       cmd_b = '0;
  logic [1:0]       cmd_op = '0;
  logic [TAG_W-1:0] cmd_tag = '0;
  logic [7:0]       ula_a;
  logic [7:0]       ula_b;
  logic [1:0]       ula_op;
  logic [7:0]       ula_r;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [7:0]       rsp_r;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  ula_seq #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op), .ula_r(ula_r),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_r(rsp_r), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Stand-in for the external ULA; a zero divisor yields all ones.
  always_comb begin
    ula_r = 8'h00;
    case (ula_op)
      2'b00: ula_r = ula_a + ula_b;
      2'b01: ula_r = ula_a - ula_b;
      2'b10: ula_r = ula_a * ula_b;
      2'b11: ula_r = (ula_b == 8'd0) ? 8'hFF : ula_a / ula_b;
      default: ula_r = 8'h00;
    endcase
  end

  typedef struct {
    int a;
    int b;
    int op;
    int tag;
  } item_t;

  item_t q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int accepted = 0;
  int last_hs = -1;
  bit chk_space = 1'b0;

  function automatic int ref_r(input int a, input int b, input int op);
    case (op)
      0: return (a + b) % 256;
      1: return (a - b + 256) % 256;
      2: return (a * b) % 256;
      default: return (b == 0) ? 255 : a / b;
    endcase
  endfunction

  task automatic chk(input string name, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  // Called #1 after an edge with inputs set: scores this cycle's handshakes, then advances one clock.
  task automatic tick();
    item_t it;
    if (cmd_valid && cmd_ready) begin
      it.a = int'(cmd_a); it.b = int'(cmd_b); it.op = int'(cmd_op); it.tag = int'(cmd_tag);
      q.push_back(it);
      accepted++;
    end
    if (rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        chk("stale_rsp", 1, 0);
      end else begin
        it = q.pop_front();
        chk("rsp_tag", int'(rsp_tag), it.tag);
        chk("rsp_r", int'(rsp_r), ref_r(it.a, it.b, it.op));
        chk("rsp_err", int'(rsp_err), (DZ_EN && it.op == 3 && it.b == 0) ? 1 : 0);
      end
      if (chk_space && last_hs >= 0) chk("rsp_spacing", cyc - last_hs, 2);
      last_hs = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    n = 0;
    while ((q.size() != 0 || rsp_valid) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_done", q.size() + int'(rsp_valid), 0);
  endtask

  task automatic set_cmd(input int a, input int b, input int op, input int tag);
    cmd_valid = 1'b1;
    cmd_a = 8'(a); cmd_b = 8'(b); cmd_op = 2'(op); cmd_tag = TAG_W'(tag);
  endtask

  initial begin
    // Reset values
    #3;
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_ula", int'({ula_a, ula_b, ula_op}), 0);
    chk("rst_rsp", int'({rsp_valid, rsp_r, rsp_tag, rsp_err}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single add with 2-cycle latency
    rsp_ready = 1'b1;
    set_cmd(100, 27, 0, 3);
    tick();
    cmd_valid = 1'b0;
    chk("add_n0_valid", int'(rsp_valid), 0);
    tick();
    chk("add_ula_a", int'(ula_a), 100);
    chk("add_ula_b", int'(ula_b), 27);
    chk("add_ula_op", int'(ula_op), 0);
    chk("add_n1_valid", int'(rsp_valid), 0);
    tick();
    chk("add_n2_valid", int'(rsp_valid), 1);
    chk("add_r", int'(rsp_r), 127);
    chk("add_tag", int'(rsp_tag), 3);
    tick();
    chk("add_after_hs", int'(rsp_valid), 0);
    tick(); tick();
    chk("add_idle", int'(rsp_valid) + q.size(), 0);

    // Backpressure: exactly DEPTH+1 accepted
    rsp_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 10; i++) begin
      set_cmd($urandom_range(0, 255), $urandom_range(1, 255), $urandom_range(0, 3), i);
      tick();
    end
    chk("bp_accepted", accepted, DEPTH + 1);
    chk("bp_full_ready", int'(cmd_ready), 0);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    chk("bp_ready_back", int'(cmd_ready), 1);
    drain(40);

    // Wraparound and each op
    begin
      int ta[4] = '{200, 5, 16, 100};
      int tb[4] = '{100, 10, 20, 7};
      for (int i = 0; i < 4; i++) begin
        set_cmd(ta[i], tb[i], i, 8 + i);
        tick();
      end
      drain(40);
    end

    // Divide by zero
    rsp_ready = 1'b0;
    set_cmd(50, 0, 3, 5);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("dz_ula_a", int'(ula_a), 50);
    chk("dz_ula_b", int'(ula_b), DZ_EN ? 1 : 0);
    tick();
    chk("dz_valid", int'(rsp_valid), 1);
    drain(20);

    // Reset while a response is held and commands are queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_cmd(i + 1, 3, 0, i);
      tick();
    end
    cmd_valid = 1'b0;
    chk("mid_valid_before", int'(rsp_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(rsp_valid), 0);
    chk("mid_rst_outs", int'({ula_a, ula_b, ula_op, rsp_r, rsp_tag, rsp_err}), 0);
    chk("mid_rst_ready", int'(cmd_ready), 1);
    #2 rst_n = 1'b1;
    q.delete();
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("mid_no_stale", int'(rsp_valid), 0);
    set_cmd(1, 1, 0, 7);
    tick();
    cmd_valid = 1'b0;
    drain(20);

    // Streaming with one push attempt per cycle: results every 2 cycles
    rsp_ready = 1'b1;
    last_hs = -1;
    chk_space = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_cmd($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 2), i);
      tick();
      checks++;
      assert (q.size() <= DEPTH + 1) else begin
        errors++;
        $error("FAIL stream_bound: observed=%0d expected<=%0d", q.size(), DEPTH + 1);
      end
    end
    drain(60);
    chk_space = 1'b0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cmd_valid = ($urandom_range(0, 9) < 7);
      cmd_a = 8'($urandom);
      cmd_b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      cmd_op = 2'($urandom);
      cmd_tag = TAG_W'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    drain(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
